axi4_burst_slave: RTL and testbench

Parametrised AXI4-style burst slave: a DEPTH-entry register file of DSZ-bit words behind independent write (AW/W/B) and read (AR/R) channels with incrementing bursts of up to 2**LSZ beats. Successor to the single-beat slave wrapper; it adds burst length, per-beat address increment, out-of-range error responses and concurrent read/write. It sits on the slave side of the same AXI4 link and uses the same channel signal set, with bresp/rresp being 1 => ok.

---
 rtl/axi4_burst_slave.sv | 230 +++++++++++++++++++++++
 tb/tb_axi4_burst_slave.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_slave.sv
// AXI4-style incrementing-burst slave over a DEPTH-word register file with independent write and read channels.
// Define AXI4_SLV_WRAP_EN to make in-range bursts wrap modulo DEPTH instead of erroring past the end.
module axi4_burst_slave #(
    parameter int DSZ   = 8,
    parameter int ASZ   = 4,
    parameter int DEPTH = 12,
    parameter int LSZ   = 4
) (
    input  logic           clk,
    input  logic           _rst,
    input  logic [ASZ-1:0] awaddr,
    input  logic [LSZ-1:0] awlen,
    input  logic           awvalid,
    output logic           awready,
    input  logic [DSZ-1:0] wdata,
    input  logic           wvalid,
    output logic           wready,
    input  logic           wlast,
    output logic           bresp,
    output logic           bvalid,
    input  logic           bready,
    input  logic [ASZ-1:0] araddr,
    input  logic [LSZ-1:0] arlen,
    input  logic           arvalid,
    output logic           arready,
    output logic [DSZ-1:0] rdata,
    output logic           rresp,
    output logic           rlast,
    output logic           rvalid,
    input  logic           rready
);

    localparam logic [ASZ:0]   DEPTH_P = (ASZ+1)'(DEPTH);
    localparam logic [ASZ:0]   PTR_ONE = (ASZ+1)'(1);
    localparam logic [LSZ-1:0] CNT_ONE = LSZ'(1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DSZ-1:0] mem [DEPTH];

    logic           rst_done;
    logic [ASZ:0]   w_ptr;
    logic [LSZ-1:0] w_len, w_cnt;
    logic           w_err;
    logic [ASZ:0]   r_ptr;
    logic [LSZ-1:0] r_len, r_cnt;
    logic [DSZ-1:0] rdata_q;
    logic           rresp_q, rlast_q;

    logic           aw_hs, w_hs, ar_hs, r_hs;
    logic           r_ld;
    logic [ASZ:0]   r_ld_ptr;
    logic [LSZ-1:0] r_ld_cnt;
    logic           r_ld_last;

    function automatic logic [ASZ:0] ptr_next(input logic [ASZ:0] p);
`ifdef AXI4_SLV_WRAP_EN
        // Only an in-range pointer can hit DEPTH-1, so out-of-range starts keep counting up and keep erroring
        if (p == DEPTH_P - PTR_ONE)
            return '0;
        return p + PTR_ONE;
`else
        return p + PTR_ONE;
`endif
    endfunction

    function automatic logic [DSZ-1:0] mem_rd(input logic [ASZ:0] p);
        logic [DSZ-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            if (p == i[ASZ:0])
                v = mem[i];
        return v;
    endfunction

    // Holds the ready outputs low until the first edge after reset release
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst)
            rst_done <= 1'b0;
        else
            rst_done <= 1'b1;
    end

    // Write channel
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst)
            w_state <= W_IDLE;
        else
            w_state <= w_next;
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = rst_done;
                if (awvalid && rst_done)
                    w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && (w_cnt == w_len))
                    w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = !w_err;
                if (bready)
                    w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            w_ptr <= '0;
            w_len <= '0;
            w_cnt <= '0;
            w_err <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (aw_hs) begin
                w_ptr <= {1'b0, awaddr};
                w_len <= awlen;
                w_cnt <= '0;
                w_err <= 1'b0;
            end
            if (w_hs) begin
                if (w_ptr < DEPTH_P) begin
                    for (int unsigned i = 0; i < DEPTH; i++)
                        if (w_ptr == i[ASZ:0])
                            mem[i] <= wdata;
                end else begin
                    w_err <= 1'b1;
                end
                if (wlast != (w_cnt == w_len))
                    w_err <= 1'b1;
                w_ptr <= ptr_next(w_ptr);
                w_cnt <= w_cnt + CNT_ONE;
            end
        end
    end

    // Read channel
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst)
            r_state <= R_IDLE;
        else
            r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = rst_done;
                if (arvalid && rst_done)
                    r_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && rlast_q)
                    r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;
    assign r_ld  = ar_hs || (r_hs && !rlast_q);

    // Pointer/count/last for the beat being loaded: beat 0 from AR, otherwise the successor beat
    always_comb begin
        r_ld_ptr  = {1'b0, araddr};
        r_ld_cnt  = '0;
        r_ld_last = (arlen == '0);
        if (r_state == R_DATA) begin
            r_ld_ptr  = ptr_next(r_ptr);
            r_ld_cnt  = r_cnt + CNT_ONE;
            r_ld_last = (r_ld_cnt == r_len);
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_ptr   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            rdata_q <= '0;
            rresp_q <= 1'b0;
            rlast_q <= 1'b0;
        end else begin
            if (ar_hs)
                r_len <= arlen;
            if (r_ld) begin
                r_ptr   <= r_ld_ptr;
                r_cnt   <= r_ld_cnt;
                rlast_q <= r_ld_last;
                if (r_ld_ptr < DEPTH_P) begin
                    rdata_q <= mem_rd(r_ld_ptr);
                    rresp_q <= 1'b1;
                end else begin
                    rdata_q <= '0;
                    rresp_q <= 1'b0;
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign rresp = rresp_q;
    assign rlast = rlast_q;

endmodule

// File: tb/tb_axi4_burst_slave.sv
// Directed plus randomized bench for axi4_burst_slave against an array-based memory model.
// Honours AXI4_SLV_WRAP_EN in its reference model.
module tb_axi4_burst_slave;

    localparam int DSZ   = 8;
    localparam int ASZ   = 4;
    localparam int DEPTH = 12;
    localparam int LSZ   = 4;
    localparam int TMO   = 50;

    logic           clk;
    logic           _rst;
    logic [ASZ-1:0] awaddr;
    logic [LSZ-1:0] awlen;
    logic           awvalid, awready;
    logic [DSZ-1:0] wdata;
    logic           wvalid, wready, wlast;
    logic           bresp, bvalid, bready;
    logic [ASZ-1:0] araddr;
    logic [LSZ-1:0] arlen;
    logic           arvalid, arready;
    logic [DSZ-1:0] rdata;
    logic           rresp, rlast, rvalid, rready;

    axi4_burst_slave #(.DSZ(DSZ), .ASZ(ASZ), .DEPTH(DEPTH), .LSZ(LSZ)) dut (
        .clk(clk), ._rst(_rst),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [DSZ-1:0] model [DEPTH];
    logic [DSZ-1:0] wbuf  [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int beat_addr(input int start, input int b);
`ifdef AXI4_SLV_WRAP_EN
        if (start < DEPTH)
            return (start + b) % DEPTH;
`endif
        return start + b;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_awready"}, awready, 0);
        chk({tag, "_wready"},  wready,  0);
        chk({tag, "_bvalid"},  bvalid,  0);
        chk({tag, "_bresp"},   bresp,   0);
        chk({tag, "_arready"}, arready, 0);
        chk({tag, "_rvalid"},  rvalid,  0);
        chk({tag, "_rdata"},   rdata,   0);
        chk({tag, "_rresp"},   rresp,   0);
        chk({tag, "_rlast"},   rlast,   0);
    endtask

    task automatic do_aw(input logic [ASZ-1:0] a, input logic [LSZ-1:0] l);
        int n;
        awaddr = a; awlen = l; awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < TMO) begin @(negedge clk); n++; end
        chk("awready", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("wready_after_aw", wready, 1);
        chk("awready_busy", awready, 0);
    endtask

    task automatic send_beat(input logic [DSZ-1:0] d, input logic last);
        int n;
        wdata = d; wlast = last; wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!wready && n < TMO) begin @(negedge clk); n++; end
        chk("wready", wready, 1);
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic write_burst(input int addr, input int len, input int wl_beat,
                               input int max_gap, input int bdelay);
        logic exp_ok;
        int   a, n;
        exp_ok = (wl_beat == len);
        for (int b = 0; b <= len; b++)
            if (beat_addr(addr, b) >= DEPTH) exp_ok = 1'b0;
        do_aw(addr[ASZ-1:0], len[LSZ-1:0]);
        for (int b = 0; b <= len; b++) begin
            repeat ($urandom_range(0, max_gap)) cyc();
            send_beat(wbuf[b], b == wl_beat);
        end
        chk("bvalid_after_last", bvalid, 1);
        repeat (bdelay) cyc();
        bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < TMO) begin @(negedge clk); n++; end
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, exp_ok);
        @(posedge clk); #1;
        bready = 1'b0;
        chk("awready_after_b", awready, 1);
        for (int b = 0; b <= len; b++) begin
            a = beat_addr(addr, b);
            if (a < DEPTH) model[a] = wbuf[b];
        end
    endtask

    // stall_mode: 0 never stall, 1 stall every beat, 2 random stalls
    task automatic read_burst(input int addr, input int len, input int stall_mode);
        logic [DSZ-1:0] exp_d [16];
        logic           exp_r [16];
        int a, n;
        for (int b = 0; b <= len; b++) begin
            a = beat_addr(addr, b);
            exp_r[b] = (a < DEPTH);
            exp_d[b] = (a < DEPTH) ? model[a] : '0;
        end
        araddr = addr[ASZ-1:0]; arlen = len[LSZ-1:0]; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < TMO) begin @(negedge clk); n++; end
        chk("arready", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk("rvalid_after_ar", rvalid, 1);
        chk("arready_busy", arready, 0);
        for (int b = 0; b <= len; b++) begin
            if (stall_mode == 1 || (stall_mode == 2 && $urandom_range(0, 1) == 1)) begin
                rready = 1'b0;
                @(negedge clk);
                chk("stall_rvalid", rvalid, 1);
                chk("stall_rdata", rdata, exp_d[b]);
                chk("stall_rlast", rlast, b == len);
                cyc();
            end
            rready = 1'b1;
            @(negedge clk);
            chk("rvalid", rvalid, 1);
            chk("rdata", rdata, exp_d[b]);
            chk("rresp", rresp, exp_r[b]);
            chk("rlast", rlast, b == len);
            @(posedge clk); #1;
            rready = 1'b0;
        end
        chk("rvalid_done", rvalid, 0);
        chk("arready_after_r", arready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        _rst = 1'b0;
        awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        repeat (2) cyc();
        check_all_zero("reset");
        @(negedge clk); #1;
        _rst = 1'b1;
        chk("awready_pre_edge", awready, 0);
        chk("arready_pre_edge", arready, 0);
        cyc();
        chk("awready_post_reset", awready, 1);
        chk("arready_post_reset", arready, 1);

        // single beat
        wbuf[0] = 8'hA5;
        write_burst(3, 0, 0, 0, 0);
        read_burst(3, 0, 0);

        // burst with backpressure
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        write_burst(4, 3, 3, 2, 1);
        read_burst(4, 3, 1);

        // end-of-memory boundary
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(i + 1);
        write_burst(10, 3, 3, 0, 0);
        read_burst(10, 3, 0);
`ifdef AXI4_SLV_WRAP_EN
        read_burst(0, 1, 0);
`endif

        // early wlast never ends the burst
        wbuf[0] = 8'h51; wbuf[1] = 8'h52; wbuf[2] = 8'h53;
        write_burst(0, 2, 1, 0, 0);
        read_burst(0, 2, 0);

        // concurrent write and read of the same burst: both beats return pre-write data
        wbuf[0] = 8'hC5; wbuf[1] = 8'hC6;
        fork
            write_burst(5, 1, 1, 0, 0);
            read_burst(5, 1, 0);
        join
        read_burst(5, 1, 0);

        // randomized traffic
        for (int t = 0; t < 12; t++) begin
            int a, l, wl;
            a = $urandom_range(0, 15);
            l = $urandom_range(0, 15);
            wl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : l;
            for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
            write_burst(a, l, wl, 2, $urandom_range(0, 2));
            read_burst($urandom_range(0, 15), $urandom_range(0, 15), 2);
        end

        // reset during beat 2 of a 4-beat write
        do_aw(2, 3);
        send_beat(8'hE0, 1'b0);
        send_beat(8'hE1, 1'b0);
        wdata = 8'hE2; wvalid = 1'b1;
        #2;
        _rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        wvalid = 1'b0;
        cyc();
        check_all_zero("mid_reset_clocked");
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #2;
        _rst = 1'b1;
        cyc();
        chk("awready_after_mid_reset", awready, 1);
        read_burst(0, DEPTH - 1, 2);
        wbuf[0] = 8'h5A;
        write_burst(0, 0, 0, 0, 0);
        read_burst(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
